// File: rtl/phy_tx_serializer.sv
// Two-lane transmit serializer: stripes 32-bit words alternately onto lane 0 and lane 1,
// MSB first, filling every empty lane slot with the idle/sync symbol.
module phy_tx_serializer #(
    parameter logic [7:0] IDLE_SYM    = 8'hBC,
    parameter int         SYNC_FRAMES = 1
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        serial_data_0,
    output logic        serial_data_1,
    output logic        tx_active
);

    localparam logic [31:0]       IDLE_WORD = {4{IDLE_SYM}};
    localparam int                SYNC_W    = (SYNC_FRAMES < 1) ? 1 : $clog2(SYNC_FRAMES + 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_FRAMES);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [4:0]        r_bitCnt;
    logic [31:0]       r_shreg0;
    logic [31:0]       r_shreg1;
    logic [31:0]       r_fifo [2];
    logic [1:0]        r_fifoCnt;
    logic              r_nextLane;
    logic [SYNC_W-1:0] r_syncCnt;
    logic              r_ready;
    logic              r_txActive;

    logic              w_load;
    logic              w_push;
    logic [31:0]       w_lane0Word;
    logic [31:0]       w_lane1Word;
    logic [1:0]        w_pops;
    logic [1:0]        w_remain;
    logic [1:0]        w_cntNxt;
    logic              w_nextLaneNxt;
    state_t            w_stateNxt;
    logic [SYNC_W-1:0] w_syncNxt;

    assign w_load = (r_bitCnt == 5'd31);
    assign w_push = valid_in && r_ready;

    // Frame contents chosen at a load edge from the FIFO as it stands before the edge.
    // SYNC holds for SYNC_FRAMES complete idle frames; RUN begins at the load edge that ends them.
    always_comb begin
        w_lane0Word   = IDLE_WORD;
        w_lane1Word   = IDLE_WORD;
        w_pops        = 2'd0;
        w_nextLaneNxt = r_nextLane;
        w_stateNxt    = r_state;
        w_syncNxt     = r_syncCnt;

        if (w_load) begin
            if (r_state == ST_SYNC) begin
                if (r_syncCnt == SYNC_LAST) begin
                    w_stateNxt = ST_RUN;
                end else begin
                    w_syncNxt = r_syncCnt + 1'b1;
                end
            end else if (!r_nextLane) begin
                if (r_fifoCnt >= 2'd2) begin
                    w_lane0Word = r_fifo[0];
                    w_lane1Word = r_fifo[1];
                    w_pops      = 2'd2;
                end else if (r_fifoCnt == 2'd1) begin
                    w_lane0Word   = r_fifo[0];
                    w_pops        = 2'd1;
                    w_nextLaneNxt = 1'b1;
                end
            end else if (r_fifoCnt >= 2'd1) begin
                w_lane1Word   = r_fifo[0];
                w_pops        = 2'd1;
                w_nextLaneNxt = 1'b0;
            end
        end

        w_remain = r_fifoCnt - w_pops;
        w_cntNxt = w_remain + {1'b0, w_push};
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_SYNC;
            r_bitCnt   <= 5'd31;
            r_shreg0   <= '0;
            r_shreg1   <= '0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_fifoCnt  <= 2'd0;
            r_nextLane <= 1'b0;
            r_syncCnt  <= '0;
            r_ready    <= 1'b0;
            r_txActive <= 1'b0;
        end else begin
            r_bitCnt   <= r_bitCnt + 5'd1;
            r_state    <= w_stateNxt;
            r_syncCnt  <= w_syncNxt;
            r_nextLane <= w_nextLaneNxt;
            r_fifoCnt  <= w_cntNxt;

            if (w_load) begin
                r_shreg0 <= w_lane0Word;
                r_shreg1 <= w_lane1Word;
            end else begin
                r_shreg0 <= {r_shreg0[30:0], 1'b0};
                r_shreg1 <= {r_shreg1[30:0], 1'b0};
            end

            // A single pop from a full FIFO promotes the second entry to the head.
            if (w_pops == 2'd1 && r_fifoCnt == 2'd2) begin
                r_fifo[0] <= r_fifo[1];
            end
            if (w_push) begin
                if (w_remain == 2'd1) begin
                    r_fifo[1] <= data_in;
                end else begin
                    r_fifo[0] <= data_in;
                end
            end

            // Ready reflects the post-edge state so a full FIFO never sees another push.
            r_ready    <= (w_stateNxt == ST_RUN) && (w_cntNxt < 2'd2);
            r_txActive <= (w_stateNxt == ST_RUN);
        end
    end

    assign serial_data_0 = r_shreg0[31];
    assign serial_data_1 = r_shreg1[31];
    assign ready_out     = r_ready;
    assign tx_active     = r_txActive;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Scoreboard bench for phy_tx_serializer: stimulus queues the expected lane frames,
// a negedge monitor reassembles each 32-bit frame on both lanes and compares.
module tb_phy_tx_serializer;

    localparam logic [31:0] IDLE = 32'hBCBCBCBC;

    typedef struct {
        logic [31:0] lane0;
        logic [31:0] lane1;
    } frame_t;

    logic        clk_32f;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        serial_data_0;
    logic        serial_data_1;
    logic        tx_active;

    int          checkCount = 0;
    int          passCount  = 0;
    int          edgeNo     = -1;
    bit          monEnable  = 0;
    int          monBits    = 0;
    int          monFrame   = 0;
    logic [31:0] monLane0   = '0;
    logic [31:0] monLane1   = '0;
    frame_t      monExp;
    frame_t      expQ[$];
    int          accEdge;

    phy_tx_serializer #(
        .IDLE_SYM   (8'hBC),
        .SYNC_FRAMES(1)
    ) dut (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .serial_data_0(serial_data_0),
        .serial_data_1(serial_data_1),
        .tx_active    (tx_active)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_32f);
        #1;
        edgeNo++;
    endtask

    task automatic tickTo(input int target);
        while (edgeNo < target) tick();
    endtask

    task automatic expectFrame(input logic [31:0] l0, input logic [31:0] l1);
        frame_t f;
        f.lane0 = l0;
        f.lane1 = l1;
        expQ.push_back(f);
    endtask

    // Offers one word and returns the edge number on which it was accepted (-1 on timeout).
    task automatic applyStimulus(input logic [31:0] word, input bit keepValid, output int acceptEdge);
        logic wasReady;
        valid_in   = 1'b1;
        data_in    = word;
        acceptEdge = -1;
        for (int i = 0; i < 64; i++) begin
            wasReady = ready_out;
            tick();
            if (wasReady) begin
                acceptEdge = edgeNo;
                break;
            end
        end
        if (!keepValid) valid_in = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input logic expReady, input logic expActive);
        checkOutput({tag, "_ready"}, {31'd0, ready_out}, {31'd0, expReady});
        checkOutput({tag, "_txActive"}, {31'd0, tx_active}, {31'd0, expActive});
    endtask

    initial begin : frameMonitor
        forever begin
            @(negedge clk_32f);
            if (!monEnable) begin
                monBits = 0;
            end else begin
                monLane0 = {monLane0[30:0], serial_data_0};
                monLane1 = {monLane1[30:0], serial_data_1};
                monBits++;
                if (monBits == 32) begin
                    monBits = 0;
                    if (expQ.size() == 0) begin
                        checkOutput($sformatf("frame%0d_expectation", monFrame), 32'(expQ.size()), 32'd1);
                    end else begin
                        monExp = expQ.pop_front();
                        checkOutput($sformatf("frame%0d_lane0", monFrame), monLane0, monExp.lane0);
                        checkOutput($sformatf("frame%0d_lane1", monFrame), monLane1, monExp.lane1);
                    end
                    monFrame++;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_serial0", {31'd0, serial_data_0}, 32'd0);
        checkOutput("rst_serial1", {31'd0, serial_data_1}, 32'd0);
        checkStatus("rst", 1'b0, 1'b0);

        repeat (3) @(negedge clk_32f);
        reset  = 1'b1;
        edgeNo = -1;

        // Sync frame, then the idle frame loaded on the edge that enters RUN.
        expectFrame(IDLE, IDLE);
        expectFrame(IDLE, IDLE);
        tick();
        monEnable = 1'b1;
        checkStatus("sync_e0", 1'b0, 1'b0);
        checkOutput("sync_e0_serial0", {31'd0, serial_data_0}, 32'd1);
        checkOutput("sync_e0_serial1", {31'd0, serial_data_1}, 32'd1);
        tickTo(31);
        checkStatus("sync_e31", 1'b0, 1'b0);
        checkOutput("sync_e31_serial0", {31'd0, serial_data_0}, 32'd0);
        tickTo(32);
        checkStatus("run_e32", 1'b1, 1'b1);

        // Single word goes to lane 0, next word then targets lane 1.
        expectFrame(32'hDEADBEEF, IDLE);
        expectFrame(IDLE, IDLE);
        applyStimulus(32'hDEADBEEF, 1'b0, accEdge);
        checkOutput("single_accept_edge", accEdge, 32'd33);
        checkStatus("single_one_queued", 1'b1, 1'b1);
        tickTo(96);
        expectFrame(IDLE, 32'h0BADF00D);
        applyStimulus(32'h0BADF00D, 1'b0, accEdge);
        checkOutput("lane1_accept_edge", accEdge, 32'd97);

        // Two words before one load edge share a frame.
        tickTo(128);
        expectFrame(32'h11223344, 32'h55667788);
        applyStimulus(32'h11223344, 1'b0, accEdge);
        applyStimulus(32'h55667788, 1'b0, accEdge);
        checkOutput("pair_accept_edge", accEdge, 32'd130);
        checkStatus("pair_full", 1'b0, 1'b1);
        tickTo(160);
        checkStatus("pair_drained", 1'b1, 1'b1);

        // Continuous valid with three words, then a fourth word lands on lane 1.
        expectFrame(32'hA0000001, 32'hA0000002);
        expectFrame(32'hA0000003, IDLE);
        expectFrame(IDLE, 32'hA0000004);
        applyStimulus(32'hA0000001, 1'b1, accEdge);
        applyStimulus(32'hA0000002, 1'b1, accEdge);
        checkStatus("burst_full", 1'b0, 1'b1);
        applyStimulus(32'hA0000003, 1'b0, accEdge);
        checkOutput("burst_third_accept_edge", accEdge, 32'd193);
        tickTo(224);
        applyStimulus(32'hA0000004, 1'b0, accEdge);
        checkOutput("burst_fourth_accept_edge", accEdge, 32'd225);

        // Push on the load edge itself waits a whole frame.
        tickTo(256);
        expectFrame(IDLE, IDLE);
        expectFrame(32'hC0FFEE55, IDLE);
        tickTo(287);
        applyStimulus(32'hC0FFEE55, 1'b0, accEdge);
        checkOutput("loadedge_accept_edge", accEdge, 32'd288);

        // Mid-frame reset with one word queued.
        tickTo(352);
        checkOutput("pre_reset_queue_empty", 32'(expQ.size()), 32'd0);
        applyStimulus(32'h99999999, 1'b0, accEdge);
        checkOutput("queued_accept_edge", accEdge, 32'd353);
        tickTo(367);
        checkStatus("pre_reset", 1'b1, 1'b1);
        monEnable = 1'b0;
        reset     = 1'b0;
        #1;
        checkOutput("midrst_serial0", {31'd0, serial_data_0}, 32'd0);
        checkOutput("midrst_serial1", {31'd0, serial_data_1}, 32'd0);
        checkStatus("midrst", 1'b0, 1'b0);
        @(posedge clk_32f);
        #1;
        checkStatus("midrst_held", 1'b0, 1'b0);
        @(negedge clk_32f);
        reset  = 1'b1;
        edgeNo = -1;
        expQ.delete();
        expectFrame(IDLE, IDLE);
        expectFrame(IDLE, IDLE);
        expectFrame(IDLE, IDLE);
        tick();
        monEnable = 1'b1;
        checkStatus("resync_e0", 1'b0, 1'b0);
        tickTo(31);
        checkStatus("resync_e31", 1'b0, 1'b0);
        tickTo(32);
        checkStatus("resync_e32", 1'b1, 1'b1);
        tickTo(96);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        monEnable = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
